// File: rtl/ult_meter_pkg.sv
// Shared types and constants for the per-player ultimate meter.
// Pure declarations: no logic, no latency, no backpressure.
package ult_meter_pkg;

   localparam int HEALTH_W = 4;
   localparam int CNT_W    = 32;

   typedef enum logic [1:0] {
      ST_DEAD     = 2'd0,
      ST_CHARGING = 2'd1,
      ST_READY    = 2'd2,
      ST_COOLDOWN = 2'd3
   } ult_state_e;

   // Last counter value of a segment period (health << shift) - 1.
   function automatic logic [CNT_W-1:0] seg_period_m1(input logic [HEALTH_W-1:0] health,
                                                     input int                  shift);
      logic [CNT_W-1:0] period;
      period = CNT_W'(health) << shift;
      return period - CNT_W'(1);
   endfunction

endpackage

// File: rtl/ult_meter_channel.sv
// One player channel: DEAD/CHARGING/READY/COOLDOWN FSM, recharge counter, meter, key edge detect.
// Outputs registered (led one cycle behind state); no backpressure, requests outside READY are dropped.
module ult_meter_channel
   import ult_meter_pkg::*;
#(
   parameter int METER_LEN       = 8,
   parameter int RECHARGE_SHIFT  = 22,
   parameter int COOLDOWN_CYCLES = 200000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [HEALTH_W-1:0]  health,
   input  logic                 ult_key,
   input  logic                 blink,
   output logic [METER_LEN-1:0] led,
   output logic                 ult_ready,
   output logic                 ult_fire
);

   localparam logic [METER_LEN-1:0] METER_FULL = '1;

   ult_state_e           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]     cd_q, cd_d;
   logic [METER_LEN-1:0] meter_q, meter_d;
   logic [METER_LEN-1:0] led_q, led_d;
   logic                 key_q, key_d;
   logic                 ready_q, ready_d;
   logic                 fire_q, fire_d;
   logic                 req;

   assign req = ult_key & ~key_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cd_d    = cd_q;
      meter_d = meter_q;
      key_d   = ult_key;
      fire_d  = 1'b0;

      case (state_q)
         ST_CHARGING: led_d = meter_q;
         ST_READY:    led_d = {METER_LEN{blink}};
         default:     led_d = '0;
      endcase

      // Zero health wins over every other event in the same cycle.
      if (health == '0) begin
         state_d = ST_DEAD;
         cnt_d   = '0;
         cd_d    = '0;
         meter_d = '0;
      end else begin
         case (state_q)
            ST_DEAD: begin
               state_d = ST_CHARGING;
               cnt_d   = '0;
               cd_d    = '0;
               meter_d = '0;
            end
            ST_CHARGING: begin
               if (cnt_q >= seg_period_m1(health, RECHARGE_SHIFT)) begin
                  cnt_d   = '0;
                  meter_d = {meter_q[METER_LEN-2:0], 1'b1};
                  if (meter_d == METER_FULL) state_d = ST_READY;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_READY: begin
               cnt_d = '0;
               if (req) begin
                  fire_d  = 1'b1;
                  meter_d = '0;
                  cd_d    = '0;
                  state_d = ST_COOLDOWN;
               end
            end
            ST_COOLDOWN: begin
               meter_d = '0;
               if (cd_q == CNT_W'(COOLDOWN_CYCLES - 1)) begin
                  state_d = ST_CHARGING;
                  cnt_d   = '0;
                  cd_d    = '0;
               end else begin
                  cd_d = cd_q + CNT_W'(1);
               end
            end
            default: state_d = ST_DEAD;
         endcase
      end

      ready_d = (state_d == ST_READY);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_DEAD;
         cnt_q   <= '0;
         cd_q    <= '0;
         meter_q <= '0;
         led_q   <= '0;
         key_q   <= 1'b0;
         ready_q <= 1'b0;
         fire_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cd_q    <= cd_d;
         meter_q <= meter_d;
         led_q   <= led_d;
         key_q   <= key_d;
         ready_q <= ready_d;
         fire_q  <= fire_d;
      end
   end

   assign led       = led_q;
   assign ult_ready = ready_q;
   assign ult_fire  = fire_q;

endmodule

// File: rtl/multi_player_ult_meter.sv
// Multi-player ultimate meters: NUM_PLAYERS independent channels sharing one blink generator.
// All outputs registered (led one cycle behind channel state); no backpressure.
module multi_player_ult_meter
   import ult_meter_pkg::*;
#(
   parameter int NUM_PLAYERS     = 2,
   parameter int METER_LEN       = 8,
   parameter int RECHARGE_SHIFT  = 22,
   parameter int COOLDOWN_CYCLES = 200000,
   parameter int BLINK_HALF      = 10000000
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [HEALTH_W*NUM_PLAYERS-1:0] health,
   input  logic [NUM_PLAYERS-1:0]          ult_key,
   output logic [METER_LEN*NUM_PLAYERS-1:0] led,
   output logic [NUM_PLAYERS-1:0]          ult_ready,
   output logic [NUM_PLAYERS-1:0]          ult_fire
);

   logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             blink_q, blink_d;

   always_comb begin
      blink_cnt_d = blink_cnt_q + CNT_W'(1);
      blink_d     = blink_q;
      if (blink_cnt_q == CNT_W'(BLINK_HALF - 1)) begin
         blink_cnt_d = '0;
         blink_d     = ~blink_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
      end
   end

   // Player 0 drives the most-significant led group.
   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_ch
      ult_meter_channel #(
         .METER_LEN       (METER_LEN),
         .RECHARGE_SHIFT  (RECHARGE_SHIFT),
         .COOLDOWN_CYCLES (COOLDOWN_CYCLES)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .health    (health[HEALTH_W*p +: HEALTH_W]),
         .ult_key   (ult_key[p]),
         .blink     (blink_q),
         .led       (led[METER_LEN*(NUM_PLAYERS-1-p) +: METER_LEN]),
         .ult_ready (ult_ready[p]),
         .ult_fire  (ult_fire[p])
      );
   end

endmodule
